// File: rtl/seq_shift_unit.sv
// seq_shift_unit: iterative multi-mode shifter, one bit position per clock.
// Modes: 00 logical right, 01 arithmetic right, 10 rotate right, 11 logical left.
// A request is captured in IDLE, shifted in SHIFT and presented in DONE until taken.
module seq_shift_unit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] sh_amt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    W_CNT = CW'(WIDTH);
  localparam logic [CW-1:0]    ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [1:0]      mode_q;
  logic [CW-1:0]   n_eff;

  // Rotation wraps the amount; the other modes saturate at WIDTH, since
  // shifting further cannot change the result.
  function automatic logic [CW-1:0] eff_amount(input logic [WIDTH-1:0] amt,
                                               input logic [1:0]       m);
    logic [WIDTH-1:0] rem;
    begin
      rem = amt % W_VAL;
      if (m == 2'b10)
        eff_amount = CW'(rem);
      else if (amt >= W_VAL)
        eff_amount = W_CNT;
      else
        eff_amount = CW'(amt);
    end
  endfunction

  // Single-bit step for the latched mode.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                            input logic [1:0]       m);
    begin
      case (m)
        2'b00:   step = {1'b0, v[WIDTH-1:1]};
        2'b01:   step = {v[WIDTH-1], v[WIDTH-1:1]};
        2'b10:   step = {v[0], v[WIDTH-1:1]};
        default: step = {v[WIDTH-2:0], 1'b0};
      endcase
    end
  endfunction

  assign n_eff = eff_amount(sh_amt, mode);

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; a result take and a new accept never share an edge
  // because acceptance is only possible from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid)
          state_nxt = (n_eff == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (count == ONE)
          state_nxt = DONE;
      end
      DONE: begin
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
    busy = ~in_ready;
  end

  // Datapath: capture on accept, one step per SHIFT cycle, hold in DONE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      d      <= '0;
      count  <= '0;
      mode_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d      <= a;
            count  <= n_eff;
            mode_q <= mode;
          end
        end
        SHIFT: begin
          d     <= step(d, mode_q);
          count <= count - ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed vectors for seq_shift_unit (WIDTH=8 and WIDTH=2).
module tb_seq_shift_unit;

  logic       Clk;
  logic       Rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] a, sh_amt, d;
  logic [1:0] mode;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [1:0] a2, sh_amt2, d2, mode2;

  int n_checks = 0;
  int n_pass   = 0;

  seq_shift_unit #(.WIDTH(8)) u_dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .sh_amt(sh_amt), .mode(mode), .d(d), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  seq_shift_unit #(.WIDTH(2)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .sh_amt(sh_amt2), .mode(mode2), .d(d2), .out_valid(out_valid2),
    .out_ready(out_ready2), .busy(busy2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one op, measure latency from the accept edge, check result, then take it.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] isa,
                        input logic [1:0] im, input logic [7:0] exp_d, input int exp_lat);
    int lat;
    chk({tag, "_idle"}, in_ready, 1'b1);
    a = ia; sh_amt = isa; mode = im; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Scramble inputs: the unit must use what it captured.
    a = 8'hA5; sh_amt = 8'd7; mode = 2'b11;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk({tag, "_ready_low"}, in_ready, 1'b0);
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_d"}, d, exp_d);
    chk({tag, "_busy"}, busy, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_taken"}, out_valid, 1'b0);
    chk({tag, "_ready_after"}, in_ready, 1'b1);
  endtask

  initial begin
    Rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; sh_amt = '0; mode = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; sh_amt2 = '0; mode2 = '0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_d", d, 8'h00);
    @(posedge Clk); #1;
    Rst = 1'b0;
    tick();

    run_op("lsr2",   8'hB4, 8'd2,   2'b00, 8'h2D, 3);
    run_op("asr3",   8'h90, 8'd3,   2'b01, 8'hF2, 4);
    run_op("asr255", 8'h90, 8'd255, 2'b01, 8'hFF, 9);
    run_op("ror1",   8'h81, 8'd1,   2'b10, 8'hC0, 2);
    run_op("ror9",   8'h81, 8'd9,   2'b10, 8'hC0, 2);
    run_op("ror8",   8'h81, 8'd8,   2'b10, 8'h81, 1);
    run_op("lsl4",   8'h0F, 8'd4,   2'b11, 8'hF0, 5);
    run_op("lsr200", 8'hFF, 8'd200, 2'b00, 8'h00, 9);
    run_op("lsl8",   8'h01, 8'd8,   2'b11, 8'h00, 9);
    run_op("asr7",   8'h40, 8'd7,   2'b01, 8'h00, 8);

    // Zero shift, then hold the result while new requests are offered.
    a = 8'h5A; sh_amt = 8'd0; mode = 2'b00; in_valid = 1'b1;
    tick();
    chk("zero_valid", out_valid, 1'b1);
    chk("zero_d", d, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      a = 8'h11 + 8'(i); sh_amt = 8'd3; in_valid = (i % 2 == 0);
      tick();
      chk("hold_d", d, 8'h5A);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_ready", in_ready, 1'b0);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("take_ready", in_ready, 1'b1);
    chk("take_no_accept", out_valid, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("still_idle", in_ready, 1'b1);

    // Asynchronous reset two cycles into SHIFT.
    a = 8'hC3; sh_amt = 8'd6; mode = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    #2 Rst = 1'b1;
    #1;
    chk("arst_d", d, 8'h00);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    tick();
    Rst = 1'b0;
    tick();
    run_op("post_rst", 8'h02, 8'd1, 2'b00, 8'h01, 2);

    // WIDTH=2 instance.
    a2 = 2'b10; sh_amt2 = 2'd1; mode2 = 2'b00; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    chk("w2_shift", out_valid2, 1'b0);
    tick();
    chk("w2_valid", out_valid2, 1'b1);
    chk("w2_d", d2, 2'b01);
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    chk("w2_ready", in_ready2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
